audio_codec_link: RTL
=====================

// Module: audio_codec_link
// PURPOSE
// Codec-side end of the Computer_System audio serial link: acts as bit-clock master.
// Generates BCLK/ADCLRCK/DACLRCK, serialises ADC samples onto ADCDAT and deserialises DACDAT.
// Used as the codec stand-in for audio-path bring-up and as the peer for audio_* conduit tests.
// Format: left-justified, MSB first, LRCK high = left channel.
// PARAMETERS
// DATA_WIDTH  16  sample width per channel; must be <= SLOT_BITS
// SLOT_BITS   32  BCLK periods per channel slot (frame = 2*SLOT_BITS BCLK)
// BCLK_DIV     8  clk cycles per BCLK half-period; must be >= 4 (default: 1024 clk/frame)
// PORTS
// clk             in   1           system clock; all logic on rising edge
// reset           in   1           synchronous, active-high
// adc_left_data   in   DATA_WIDTH  left sample to transmit
// adc_right_data  in   DATA_WIDTH  right sample to transmit
// adc_valid       in   1           stereo pair offered
// adc_ready       out  1           holding register empty; pair accepted when valid&&ready
// adc_underrun    out  1           1-clk pulse: frame started with empty holding register
// dac_left_data   out  DATA_WIDTH  last received left sample
// dac_right_data  out  DATA_WIDTH  last received right sample
// dac_valid       out  1           1-clk pulse: new stereo pair on dac_*_data
// BCLK            out  1           bit clock, period 2*BCLK_DIV clk
// ADCLRCK         out  1           ADC frame clock (identical to DACLRCK)
// DACLRCK         out  1           DAC frame clock
// ADCDAT          out  1           serial ADC data
// DACDAT          in   1           serial DAC data (async; 2-FF synchronised internally)
// BEHAVIOUR
// Reset values: BCLK=0, ADCLRCK=DACLRCK=1, ADCDAT=0, adc_ready=1, adc_underrun=0,
//   dac_valid=0, dac_*_data=0; div_cnt=0, bit_cnt=0, holding empty, shifters/last sample=0.
// Divider: div_cnt 0..BCLK_DIV-1; at BCLK_DIV-1 BCLK toggles (registered), div_cnt->0.
//   Rise event = cycle BCLK goes 0->1; fall event = cycle BCLK goes 1->0. First rise after BCLK_DIV clk.
// bit_cnt 0..2*SLOT_BITS-1 advances on each fall event, wraps to 0 (frame start).
// LRCK = (bit_cnt < SLOT_BITS), updated with bit_cnt on fall event; both LRCK outputs equal.
// ADCDAT: slot index i = bit_cnt mod SLOT_BITS; i < DATA_WIDTH -> current slot shifter bit
//   [DATA_WIDTH-1-i] (MSB first); i >= DATA_WIDTH -> 0. Changes only on fall events.
// Frame load (fall event with bit_cnt wrap to 0): if holding full -> shifters <= holding,
//   last <= holding, holding emptied (adc_ready=1 next clk); else shifters <= last
//   (repeat previous pair), adc_underrun pulses that cycle. First frame after reset sends zeros.
// Holding write: valid&&ready loads pair, adc_ready=0 next clk. Write in frame-load cycle
//   is kept for the NEXT frame; load uses pre-write holding state (underrun if it was empty).
// DACDAT: sampled from synchroniser output on each rise event; bits with i < DATA_WIDTH
//   shifted in MSB first, padding bits ignored. Left word held internally after bit DATA_WIDTH-1.
// Right capture of i = DATA_WIDTH-1: next clk dac_left_data/dac_right_data update together
//   and dac_valid=1 for exactly one clk; otherwise dac_valid=0, data outputs hold.
// Reset mid-operation: all state to reset values next clk; pending holding pair and partial
//   DAC words discarded; no dac_valid for the interrupted frame.
// Widths: counters sized by $clog2; no arithmetic on sample data (pure shift/copy).
// TESTING
// 1 Reset, free-run, adc_valid=0: BCLK period 16 clk, LRCK period 1024, high 512; ADCDAT=0 frame 1;
//   adc_underrun pulses at each frame start.
// 2 Write L=16'hA5C3 R=16'h0F0F mid-frame: adc_ready=0 until frame load+1; next frame left slot
//   ADCDAT=1010010111000011 then 16 zeros, right slot 0000111100001111 then 16 zeros.
// 3 Model drives DACDAT L=16'h8001 R=16'h7FFE on BCLK falls, padding=1s: one dac_valid per frame,
//   dac_left_data=16'h8001, dac_right_data=16'h7FFE; padding has no effect.
// 4 One pair written then none: following frame repeats same pair, adc_underrun=1 for 1 clk.
// 5 Write on exact frame-load cycle with holding empty: underrun pulse that cycle, pair sent next frame.
// 6 Reset asserted at bit_cnt=40: next clk BCLK=0, LRCK=1, ADCDAT=0, adc_ready=1; no dac_valid
//   until a full new frame completes.

Source files
------------

// File: rtl/audio_codec_link.sv
// audio_codec_link: codec-side end of the audio serial link, acting as bit-clock
// master. Generates BCLK and the shared LR frame clock, serialises the ADC stereo
// pair onto ADCDAT and deserialises DACDAT back into a stereo pair.
// Format: left-justified, MSB first, LRCK high = left channel.
//
// ADC handshake: a pair on adc_left_data/adc_right_data is transferred on any
// rising clk edge where adc_valid && adc_ready; adc_ready is 1 exactly when the
// single-entry holding register is empty, and does not depend on adc_valid.
// The producer holds data stable while valid is high and ready is low.

module audio_codec_link #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_BITS  = 32,
    parameter int BCLK_DIV   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] adc_left_data,
    input  logic [DATA_WIDTH-1:0] adc_right_data,
    input  logic                  adc_valid,
    output logic                  adc_ready,
    output logic                  adc_underrun,
    output logic [DATA_WIDTH-1:0] dac_left_data,
    output logic [DATA_WIDTH-1:0] dac_right_data,
    output logic                  dac_valid,
    output logic                  BCLK,
    output logic                  ADCLRCK,
    output logic                  DACLRCK,
    output logic                  ADCDAT,
    input  logic                  DACDAT
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] DW_N     = BIT_W'(DATA_WIDTH);
    localparam logic [BIT_W-1:0] DW_LAST  = BIT_W'(DATA_WIDTH - 1);

    // Bit position inside the current channel slot (frame bit mod SLOT_BITS).
    function automatic logic [BIT_W-1:0] slot_index(input logic [BIT_W-1:0] bc);
        return (bc >= SLOT_N) ? (bc - SLOT_N) : bc;
    endfunction

    // Bit-clock divider
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             tick;
    logic             rise_evt;
    logic             fall_evt;

    // Frame position
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             lrck_q, lrck_d;
    logic             frame_load;

    // ADC side: holding register and the pair currently being sent (also the
    // pair that is repeated when the producer falls behind)
    logic                  adc_accept;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic [DATA_WIDTH-1:0] tx_l_q, tx_l_d;
    logic [DATA_WIDTH-1:0] tx_r_q, tx_r_d;
    logic                  underrun_q, underrun_d;
    logic                  adcdat_q, adcdat_d;
    logic [BIT_W-1:0]      tx_idx;
    logic [DATA_WIDTH-1:0] tx_word;
    logic [DATA_WIDTH-1:0] tx_shift;

    // DAC side: synchroniser, shift register, captured left word, outputs
    logic                  dacdat_s1_q;
    logic                  dacdat_s2_q;
    logic [BIT_W-1:0]      rx_idx;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] rx_left_q, rx_left_d;
    logic [DATA_WIDTH-1:0] dac_left_q, dac_left_d;
    logic [DATA_WIDTH-1:0] dac_right_q, dac_right_d;
    logic                  dac_valid_q, dac_valid_d;

    // Divider: BCLK toggles every BCLK_DIV clk; edge events are the toggle cycles.
    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        rise_evt  = tick && !bclk_q;
        fall_evt  = tick && bclk_q;
        div_cnt_d = tick ? '0 : (div_cnt_q + DIV_W'(1));
        bclk_d    = tick ? ~bclk_q : bclk_q;
    end

    // Frame counter advances on BCLK falls; LRCK follows the new position.
    always_comb begin
        frame_load = fall_evt && (bit_cnt_q == BIT_LAST);
        bit_cnt_d  = bit_cnt_q;
        lrck_d     = lrck_q;
        if (fall_evt) begin
            bit_cnt_d = frame_load ? '0 : (bit_cnt_q + BIT_W'(1));
            lrck_d    = (bit_cnt_d < SLOT_N);
        end
    end

    // Holding register write and frame load; the load looks only at the
    // pre-write holding state, so a write in the load cycle waits a frame.
    always_comb begin
        adc_accept  = adc_valid && !hold_full_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        tx_l_d      = tx_l_q;
        tx_r_d      = tx_r_q;
        underrun_d  = 1'b0;
        if (frame_load) begin
            if (hold_full_q) begin
                tx_l_d      = hold_l_q;
                tx_r_d      = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                // Nothing new: tx pair is kept and therefore repeated.
                underrun_d = 1'b1;
            end
        end
        if (adc_accept) begin
            hold_l_d    = adc_left_data;
            hold_r_d    = adc_right_data;
            hold_full_d = 1'b1;
        end
    end

    // ADCDAT: on each BCLK fall present the bit for the new frame position,
    // MSB first within the slot, zero in the padding bits.
    always_comb begin
        tx_idx   = slot_index(bit_cnt_d);
        tx_word  = (bit_cnt_d < SLOT_N) ? tx_l_d : tx_r_d;
        tx_shift = tx_word << tx_idx;
        adcdat_d = adcdat_q;
        if (fall_evt) begin
            adcdat_d = (tx_idx < DW_N) ? tx_shift[DATA_WIDTH-1] : 1'b0;
        end
    end

    // DACDAT: shift in data bits on BCLK rises, park the left word, and publish
    // both words together when the last right data bit arrives.
    always_comb begin
        rx_idx      = slot_index(bit_cnt_q);
        rx_next     = (rx_sr_q << 1) | DATA_WIDTH'(dacdat_s2_q);
        rx_sr_d     = rx_sr_q;
        rx_left_d   = rx_left_q;
        dac_left_d  = dac_left_q;
        dac_right_d = dac_right_q;
        dac_valid_d = 1'b0;
        if (rise_evt && (rx_idx < DW_N)) begin
            rx_sr_d = rx_next;
            if (rx_idx == DW_LAST) begin
                if (bit_cnt_q < SLOT_N) begin
                    rx_left_d = rx_next;
                end else begin
                    dac_left_d  = rx_left_q;
                    dac_right_d = rx_next;
                    dac_valid_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset; reset discards any pending pair
    // and partially received DAC words.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            bit_cnt_q   <= '0;
            lrck_q      <= 1'b1;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            tx_l_q      <= '0;
            tx_r_q      <= '0;
            underrun_q  <= 1'b0;
            adcdat_q    <= 1'b0;
            dacdat_s1_q <= 1'b0;
            dacdat_s2_q <= 1'b0;
            rx_sr_q     <= '0;
            rx_left_q   <= '0;
            dac_left_q  <= '0;
            dac_right_q <= '0;
            dac_valid_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bclk_q      <= bclk_d;
            bit_cnt_q   <= bit_cnt_d;
            lrck_q      <= lrck_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            tx_l_q      <= tx_l_d;
            tx_r_q      <= tx_r_d;
            underrun_q  <= underrun_d;
            adcdat_q    <= adcdat_d;
            dacdat_s1_q <= DACDAT;
            dacdat_s2_q <= dacdat_s1_q;
            rx_sr_q     <= rx_sr_d;
            rx_left_q   <= rx_left_d;
            dac_left_q  <= dac_left_d;
            dac_right_q <= dac_right_d;
            dac_valid_q <= dac_valid_d;
        end
    end

    assign BCLK           = bclk_q;
    assign ADCLRCK        = lrck_q;
    assign DACLRCK        = lrck_q;
    assign ADCDAT         = adcdat_q;
    assign adc_ready      = ~hold_full_q;
    assign adc_underrun   = underrun_q;
    assign dac_left_data  = dac_left_q;
    assign dac_right_data = dac_right_q;
    assign dac_valid      = dac_valid_q;

endmodule
